// File: rtl/pio_rmw_arbiter.sv
// Round-robin Avalon-MM master sharing one PIO output register between requesters.
// Every access reads the register first; writes merge the requester's masked bits back.
module pio_rmw_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_rnw,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  input  logic [NUM_REQ*DATA_W-1:0] req_wmask,
  output logic [NUM_REQ-1:0]        req_done,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      busy,
  output logic [1:0]                address,
  output logic                      chipselect,
  output logic                      write_n,
  output logic [31:0]               writedata,
  input  logic [31:0]               readdata
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t              r_state;
  logic [IW-1:0]       r_last, r_gnt;
  logic                r_rnw;
  logic [DATA_W-1:0]   r_wdata, r_wmask, r_old;

  logic                w_gnt_vld;
  logic [IW-1:0]       w_gnt;
  logic [DATA_W-1:0]   w_old, w_merge;
  logic                w_unused;

  function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return s[IW-1:0];
  endfunction

  // Scan from farthest to nearest so the nearest set bit after r_last wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req[rr_idx(r_last, k)]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = rr_idx(r_last, k);
      end
    end
  end

  assign w_old    = readdata[DATA_W-1:0];
  assign w_merge  = (w_old & ~r_wmask) | (r_wdata & r_wmask);
  assign w_unused = ^readdata[31:DATA_W];
  assign address  = 2'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_last     <= IW'(NUM_REQ-1);
      r_gnt      <= '0;
      r_rnw      <= 1'b0;
      r_wdata    <= '0;
      r_wmask    <= '0;
      r_old      <= '0;
      chipselect <= 1'b0;
      write_n    <= 1'b1;
      writedata  <= '0;
      req_done   <= '0;
      rsp_rdata  <= '0;
      busy       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_gnt_vld) begin
          r_gnt      <= w_gnt;
          r_rnw      <= req_rnw[w_gnt];
          r_wdata    <= req_wdata[w_gnt*DATA_W +: DATA_W];
          r_wmask    <= req_wmask[w_gnt*DATA_W +: DATA_W];
          chipselect <= 1'b1;
          write_n    <= 1'b1;
          busy       <= 1'b1;
          r_state    <= RD;
        end
        RD: begin
          r_old <= w_old;
          if (r_rnw) begin
            chipselect <= 1'b0;
            req_done   <= NUM_REQ'(1) << r_gnt;
            rsp_rdata  <= w_old;
            r_state    <= RESP;
          end else begin
            write_n   <= 1'b0;
            writedata <= 32'(w_merge);
            r_state   <= WR;
          end
        end
        WR: begin
          chipselect <= 1'b0;
          write_n    <= 1'b1;
          req_done   <= NUM_REQ'(1) << r_gnt;
          rsp_rdata  <= r_old;
          r_state    <= RESP;
        end
        RESP: begin
          req_done <= '0;
          r_last   <= r_gnt;
          busy     <= 1'b0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pio_rmw_arbiter.sv
// Bench for pio_rmw_arbiter: directed cycle checks plus randomized bursts against
// a round-robin / masked-merge reference model and a behavioural PIO register.
module tb_pio_rmw_arbiter;
  localparam int N = 4;
  localparam int W = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req, req_rnw, req_done;
  logic [N*W-1:0]   req_wdata, req_wmask;
  logic [W-1:0]     rsp_rdata;
  logic             busy, chipselect, write_n;
  logic [1:0]       address;
  logic [31:0]      writedata, readdata;

  logic [W-1:0]     pio, pio_val, m_pio;
  logic             pio_load = 1'b0;
  int               n_chk = 0, n_fail = 0;

  pio_rmw_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
    .clk(clk), .reset(reset), .req(req), .req_rnw(req_rnw),
    .req_wdata(req_wdata), .req_wmask(req_wmask), .req_done(req_done),
    .rsp_rdata(rsp_rdata), .busy(busy), .address(address),
    .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
    .readdata(readdata)
  );

  always #5 clk = ~clk;

  // PIO slave: zero wait-state register at address 0, combinational readdata.
  always @(posedge clk) begin
    if (pio_load) pio <= pio_val;
    else if (chipselect && !write_n && address == 2'd0) pio <= writedata[W-1:0];
  end
  assign readdata = {{(32-W){1'b0}}, pio};

  function automatic int rr_next(input logic [N-1:0] p, input int last);
    for (int k = 1; k <= N; k++) if (p[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic preload(input logic [W-1:0] v);
    @(negedge clk); pio_load = 1'b1; pio_val = v;
    @(negedge clk); pio_load = 1'b0; m_pio = v;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; req_rnw = '0; req_wdata = '0; req_wmask = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic set_req(input int i, input logic rnw, input logic [W-1:0] d, input logic [W-1:0] m);
    req_rnw[i] = rnw;
    req_wdata[i*W +: W] = d;
    req_wmask[i*W +: W] = m;
  endtask

  task automatic wait_done(output int idx, output int cyc);
    idx = -1; cyc = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (req_done != '0) begin
        cyc = c; idx = -2;
        for (int i = 0; i < N; i++) if (req_done == (N'(1) << i)) idx = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_chk++;
    if ({chipselect, write_n, writedata, address} !== {1'b0, 1'b1, 32'h0, 2'd0}) begin
      n_fail++; $display("FAIL reset_bus: got cs=%b wn=%b wd=%h a=%h", chipselect, write_n, writedata, address);
    end
    n_chk++;
    if ({req_done, rsp_rdata, busy} !== {4'b0, 5'b0, 1'b0}) begin
      n_fail++; $display("FAIL reset_rsp: got done=%b rd=%b busy=%b want 0", req_done, rsp_rdata, busy);
    end
    reset = 1'b0;
    preload(5'b00000);
  endtask

  task automatic test_write_basic();
    set_req(0, 1'b0, 5'b10101, 5'b11111); req = 4'b0001;
    @(negedge clk);
    n_chk++;
    if ({chipselect, write_n, busy} !== 3'b111) begin
      n_fail++; $display("FAIL wr_rd_phase: got cs/wn/busy=%b want 111", {chipselect, write_n, busy});
    end
    @(negedge clk);
    n_chk++;
    if ({chipselect, write_n, writedata} !== {1'b1, 1'b0, 32'h15}) begin
      n_fail++; $display("FAIL wr_wr_phase: got cs=%b wn=%b wd=%h want 1 0 15", chipselect, write_n, writedata);
    end
    @(negedge clk);
    n_chk++;
    if ({req_done, chipselect, pio} !== {4'b0001, 1'b0, 5'b10101}) begin
      n_fail++; $display("FAIL wr_done: got done=%b cs=%b pio=%b want 0001 0 10101", req_done, chipselect, pio);
    end
    req = '0; m_pio = 5'b10101;
    @(negedge clk);
    n_chk++;
    if ({req_done, busy} !== 5'b0) begin
      n_fail++; $display("FAIL wr_idle: got done=%b busy=%b want 0", req_done, busy);
    end
  endtask

  task automatic test_masked_write();
    set_req(1, 1'b0, 5'b00010, 5'b00011); req = 4'b0010;
    repeat (2) @(negedge clk);
    n_chk++;
    if (writedata !== 32'h16) begin
      n_fail++; $display("FAIL mask_wdata: got %h want 16", writedata);
    end
    @(negedge clk);
    n_chk++;
    if ({req_done, rsp_rdata, pio} !== {4'b0010, 5'b10101, 5'b10110}) begin
      n_fail++; $display("FAIL mask_done: got done=%b rd=%b pio=%b want 0010 10101 10110", req_done, rsp_rdata, pio);
    end
    req = '0; m_pio = 5'b10110;
    @(negedge clk);
  endtask

  task automatic test_read_only();
    logic wn_ok;
    int   c;
    preload(5'b01100);
    set_req(2, 1'b1, 5'b11111, 5'b11111); req = 4'b0100;
    wn_ok = 1'b1; c = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (!write_n) wn_ok = 1'b0;
      if (req_done != '0) begin c = k; break; end
    end
    n_chk++;
    if (c !== 2) begin n_fail++; $display("FAIL rd_latency: got %0d want 2", c); end
    n_chk++;
    if ({req_done, rsp_rdata, wn_ok, pio} !== {4'b0100, 5'b01100, 1'b1, 5'b01100}) begin
      n_fail++; $display("FAIL rd_done: got done=%b rd=%b wn_ok=%b pio=%b", req_done, rsp_rdata, wn_ok, pio);
    end
    req = '0;
    @(negedge clk);
  endtask

  // Pointer sits at 2 here; a surviving pointer would grant 3 before 0.
  task automatic test_reset_mid();
    int idx, cyc;
    set_req(3, 1'b0, 5'b00011, 5'b11111); req = 4'b1000;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({chipselect, write_n} !== 2'b10) begin
      n_fail++; $display("FAIL rst_pre_wr: got cs/wn=%b want 10", {chipselect, write_n});
    end
    #2 reset = 1'b1;
    #1;
    n_chk++;
    if ({chipselect, write_n, busy, req_done} !== {3'b010, 4'b0}) begin
      n_fail++; $display("FAIL rst_abort: got cs=%b wn=%b busy=%b done=%b", chipselect, write_n, busy, req_done);
    end
    req = '0;
    @(negedge clk);
    n_chk++;
    if ({req_done, pio} !== {4'b0, m_pio}) begin
      n_fail++; $display("FAIL rst_nowrite: got done=%b pio=%b want 0000 %b", req_done, pio, m_pio);
    end
    reset = 1'b0;
    set_req(0, 1'b1, 5'b0, 5'b0); set_req(3, 1'b1, 5'b0, 5'b0); req = 4'b1001;
    wait_done(idx, cyc);
    n_chk++;
    if (idx !== 0) begin n_fail++; $display("FAIL rst_first_grant: got %0d want 0", idx); end
    req[0] = 1'b0;
    wait_done(idx, cyc);
    n_chk++;
    if (idx !== 3) begin n_fail++; $display("FAIL rst_second_grant: got %0d want 3", idx); end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int idx, cyc;
    logic [W-1:0] d[N], m[N];
    do_reset();
    preload(5'($urandom));
    for (int i = 0; i < N; i++) begin
      d[i] = 5'($urandom); m[i] = 5'($urandom);
      set_req(i, 1'b0, d[i], m[i]);
    end
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      wait_done(idx, cyc);
      n_chk++;
      if (idx !== t % N || cyc !== (t == 0 ? 3 : 4)) begin
        n_fail++; $display("FAIL rr_order t=%0d: got idx=%0d cyc=%0d want %0d %0d", t, idx, cyc, t % N, (t == 0 ? 3 : 4));
      end
      n_chk++;
      if (rsp_rdata !== m_pio) begin
        n_fail++; $display("FAIL rr_rdata t=%0d: got %b want %b", t, rsp_rdata, m_pio);
      end
      m_pio = (m_pio & ~m[t % N]) | (d[t % N] & m[t % N]);
      n_chk++;
      if (pio !== m_pio) begin
        n_fail++; $display("FAIL rr_pio t=%0d: got %b want %b", t, pio, m_pio);
      end
    end
    req = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_pointer();
    int idx, cyc;
    do_reset();
    set_req(1, 1'b1, 5'b0, 5'b0); set_req(3, 1'b1, 5'b0, 5'b0); req = 4'b1010;
    wait_done(idx, cyc);
    n_chk++;
    if (idx !== 1) begin n_fail++; $display("FAIL ptr_first: got %0d want 1", idx); end
    req[1] = 1'b0;
    wait_done(idx, cyc);
    n_chk++;
    if (idx !== 3) begin n_fail++; $display("FAIL ptr_second: got %0d want 3", idx); end
    req = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    int idx, cyc, g, last, exp_cyc;
    logic [N-1:0] pend;
    logic [W-1:0] d[N], m[N];
    logic         rnw[N];
    logic         first;
    do_reset();
    last = N - 1;
    for (int it = 0; it < 30; it++) begin
      pend = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        rnw[i] = 1'($urandom); d[i] = 5'($urandom); m[i] = 5'($urandom);
        set_req(i, rnw[i], d[i], m[i]);
      end
      req = pend; first = 1'b1;
      while (pend != '0) begin
        g = rr_next(pend, last);
        exp_cyc = (rnw[g] ? 2 : 3) + (first ? 0 : 1);
        wait_done(idx, cyc);
        n_chk++;
        if (idx !== g || cyc !== exp_cyc) begin
          n_fail++; $display("FAIL rnd_grant it=%0d: got idx=%0d cyc=%0d want %0d %0d", it, idx, cyc, g, exp_cyc);
        end
        if (idx < 0) begin pend = '0; req = '0; break; end
        n_chk++;
        if (rsp_rdata !== m_pio) begin
          n_fail++; $display("FAIL rnd_rdata it=%0d: got %b want %b", it, rsp_rdata, m_pio);
        end
        if (!rnw[g]) m_pio = (m_pio & ~m[g]) | (d[g] & m[g]);
        n_chk++;
        if (pio !== m_pio) begin
          n_fail++; $display("FAIL rnd_pio it=%0d: got %b want %b", it, pio, m_pio);
        end
        pend[idx] = 1'b0; req[idx] = 1'b0; last = idx; first = 1'b0;
      end
      repeat (2) @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1; req = '0; req_rnw = '0; req_wdata = '0; req_wmask = '0;
    test_reset();
    test_write_basic();
    test_masked_write();
    test_read_only();
    test_reset_mid();
    test_round_robin();
    test_pointer();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
